// File: rtl/nibble_frame_packer.sv
// -----------------------------------------------------------------------------
// nibble_frame_packer
//
// Collects a stream of NIB_W-bit nibbles, most significant first, into frames
// of four. Each completed frame is presented as the operands a..d with its
// mod-3 residue, and is held until the consumer takes it. The next frame keeps
// collecting while one is held. Input stalls only when a fourth nibble arrives
// and the held frame has not been released.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   in_nib     incoming nibble, most significant nibble of a frame first
//   in_valid   in_nib is valid
//   in_ready   a nibble can be taken this cycle (combinational)
//   flush      synchronous drop of the partial frame and the held frame
//   a,b,c,d    held frame, registered; {a,b,c,d} is the word, a is the MSN
//   out_valid  a..d and rem3 hold a complete frame
//   out_ready  consumer takes the held frame this cycle
//   rem3       {a,b,c,d} mod 3, registered
//   fill       nibbles collected in the partial frame, 0..3
// -----------------------------------------------------------------------------
module nibble_frame_packer #(
    // Must be even: the running residue relies on 2^NIB_W mod 3 == 1.
    parameter int NIB_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NIB_W-1:0] in_nib,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [NIB_W-1:0] a,
    output logic [NIB_W-1:0] b,
    output logic [NIB_W-1:0] c,
    output logic [NIB_W-1:0] d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       rem3,
    output logic [1:0]       fill
);

    localparam int SUM_W = NIB_W + 2;

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } out_state_t;

    out_state_t           state;
    logic [3*NIB_W-1:0]   shreg;     // first three nibbles of the partial frame
    logic [1:0]           prem;      // residue of the nibbles collected so far
    logic                 accept;
    logic                 complete;
    logic [SUM_W-1:0]     sum;
    logic [SUM_W-1:0]     sum_mod;
    logic [1:0]           prem_next;

    // Because 2^NIB_W == 1 (mod 3), shifting a nibble in does not change the
    // residue of the bits already collected, so the residue of the word is
    // simply the residue of the sum of its nibbles.
    assign sum       = {2'b00, in_nib} + SUM_W'(prem);
    assign sum_mod   = sum % SUM_W'(3);
    assign prem_next = sum_mod[1:0];

    assign out_valid = (state == HELD);

    // Only the fourth nibble needs a free output register; the first three
    // always have room in the shift register.
    assign in_ready  = !(out_valid && !out_ready && (fill == 2'd3));
    assign accept    = in_valid && in_ready;
    assign complete  = accept && (fill == 2'd3);

    // NOTE: every state element here is assigned with <= so all registers
    // update together from the values sampled at the same edge; a blocking
    // assignment would let later statements see half-updated state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            shreg <= '0;
            prem  <= '0;
            fill  <= '0;
            a     <= '0;
            b     <= '0;
            c     <= '0;
            d     <= '0;
            rem3  <= '0;
        end else if (flush) begin
            // The nibble offered this cycle is dropped along with everything
            // else; a..d and rem3 keep their stale values.
            state <= EMPTY;
            prem  <= '0;
            fill  <= '0;
        end else begin
            // Handoff first; a completion in the same cycle overrides it and
            // keeps the output HELD with the new frame.
            if (state == HELD && out_ready) begin
                state <= EMPTY;
            end
            if (accept) begin
                if (complete) begin
                    {a, b, c, d} <= {shreg, in_nib};
                    rem3         <= prem_next;
                    fill         <= '0;
                    prem         <= '0;
                    state        <= HELD;
                end else begin
                    shreg <= {shreg[2*NIB_W-1:0], in_nib};
                    fill  <= fill + 2'd1;
                    prem  <= prem_next;
                end
            end
        end
    end

endmodule

// File: doc/nibble_frame_packer.md
# nibble_frame_packer

Upstream feeder for the divisible-by-3 checker. Accepts a stream of 4-bit nibbles over a valid/ready handshake and assembles each group of four into the checker's `a`, `b`, `c`, `d` operands. It holds each completed frame until the consumer takes it. It also produces a running mod-3 residue per frame, so `div3.out` can be cross-checked against `rem3 == 0`.

## Interface
- `NIB_W`, default 4: nibble width. The residue logic relies on 2^NIB_W ≡ 1 (mod 3), so NIB_W must be even.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_nib` in NIB_W: incoming nibble, most significant nibble of the frame first.
- `in_valid` in 1: `in_nib` is valid.
- `in_ready` out 1: packer can accept a nibble this cycle. Combinational.
- `flush` in 1: synchronous drop of the partial frame and the held frame.
- `a`, `b`, `c`, `d` out NIB_W each: held frame, registered; `a` is most significant. The word is {a,b,c,d}.
- `out_valid` out 1: `a`..`d` and `rem3` hold a complete frame.
- `out_ready` in 1: consumer accepts the held frame this cycle.
- `rem3` out 2: {a,b,c,d} mod 3, registered, range 0..2.
- `fill` out 2: count of nibbles in the partial frame, 0..3.

## Operation
- Accept: a nibble is taken when `in_valid && in_ready`.
- Partial frame: a shift register plus `fill` counter (0..3) and a partial residue `prem`.
  - Each accepted nibble updates `prem` to (prem + in_nib) mod 3. This is valid because 16 ≡ 1 (mod 3).
  - Sum width: 2 + NIB_W bits, reduced mod 3 each nibble.
- Output register has two states:
  - EMPTY: `out_valid` = 0.
  - HELD: `out_valid` = 1.
- Completion: when a nibble is accepted with `fill` = 3:
  - The four nibbles load into `a`..`d`.
  - The final residue loads into `rem3`.
  - The output goes HELD.
  - `fill` and `prem` clear to 0.
- Handoff: in HELD, `out_ready` = 1 moves the output to EMPTY unless a completion occurs in the same cycle. In that case the output reloads with the new frame and stays HELD.
- `in_ready` = NOT (`out_valid` AND NOT `out_ready` AND `fill` == 3).
  - Collection of the next frame continues while a frame is held.
  - Input stalls only when the fourth nibble has nowhere to go.
- `a`..`d` and `rem3` never change while HELD and `out_ready` = 0.
- In EMPTY, `a`..`d` and `rem3` keep their last values; downstream ignores them.
- `flush`:
  - Clears `fill` and `prem`, and forces EMPTY.
  - The nibble presented in the flush cycle is discarded, even if `in_valid` is high.
  - `a`..`d` and `rem3` keep their values.
- Priority: `rst` > `flush` > completion/handoff.
- Reset values:
  - `a`, `b`, `c`, `d`, `rem3`, `fill` = 0.
  - `out_valid` = 0.
  - Internal shift register and `prem` = 0.
  - `in_ready` = 1 after reset, because EMPTY implies ready.
- Reset mid-frame or mid-hold discards all data. No partial frame survives.

## Timing
- Latency: the fourth nibble is accepted at edge k; `out_valid` and the new `a`..`d`/`rem3` are visible after edge k.
- Throughput:
  - One frame per 4 accepted nibbles.
  - With `out_ready` held at 1 and `in_valid` continuous: zero bubbles, and `in_ready` stays 1.
- `in_ready` depends combinationally on `out_ready`. No combinational path exists from `in_valid` to `in_ready`.
- Simultaneous handoff and completion: the old frame is consumed and the new frame is presented the next cycle. `out_valid` stays 1 with no gap.
- `fill` wraps 3 → 0 on completion only. It never reaches 4.

## Test plan
- Basic frame: reset, then `out_ready` = 0 and nibbles 1, 2, 3, 4 → one cycle after the 4th accept: a=1, b=2, c=3, d=4, rem3=1 (0x1234 = 4660), out_valid=1, fill=0.
- Residue extremes:
  - F, F, F, F → word 0xFFFF, rem3=0, so `div3.out` must be 1.
  - 0, 0, 0, 2 → rem3=2.
- Backpressure: `out_ready` = 0, offer 8 nibbles 1..8:
  - After 7 accepts, the first frame (1, 2, 3, 4) is held, fill=3, and `in_ready` = 0 with nibble 8 stalled.
  - Raise `out_ready` for one cycle → nibble 8 is accepted that cycle; next cycle a..d = 5, 6, 7, 8, rem3=2, out_valid=1.
- Streaming: `out_ready` = 1 and `in_valid` = 1 for 16 cycles with nibbles 0..F → 4 frames, `out_valid` pulses every 4th cycle, `in_ready` never drops.
- Flush mid-frame: accept 9, 9, assert `flush` with `in_valid` = 1 and `in_nib` = 7, then feed 0, 0, 0, 3 → the 7 is discarded; frame 0x0003 with rem3=0; no frame containing 9 appears.
- Reset mid-hold: frame held and fill=2, assert `rst` one cycle → out_valid=0, fill=0, a..d=0, rem3=0, in_ready=1; the next 4 nibbles form a clean frame.
